// File: rtl/xpb_pkg.sv
// Shared constants and FSM state encoding for the xpb reduction folder.
// ACC_W carries enough headroom for the seed plus every folded LUT value.
package xpb_pkg;

    localparam int DATA_W  = 1024;
    localparam int IDX_W   = 5;
    localparam int NUM_SEG = 8;
    localparam int SEG_W   = $clog2(NUM_SEG);
    localparam int ACC_W   = DATA_W + $clog2(NUM_SEG + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/xpb_acc_add.sv
// Registered wide accumulator: load a zero-extended seed, add a zero-extended
// operand, or hold. Load wins over add when both are requested.
module xpb_acc_add
    import xpb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_add,
    input  logic [DATA_W-1:0] i_load_val,
    input  logic [DATA_W-1:0] i_add_val,
    output logic [ACC_W-1:0]  o_acc
);

    localparam int PAD_W = ACC_W - DATA_W;

    logic [ACC_W-1:0] r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= {{PAD_W{1'b0}}, i_load_val};
        end else if (i_add) begin
            r_acc <= r_acc + {{PAD_W{1'b0}}, i_add_val};
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/xpb_fold_accum.sv
// Sequential fold of the upper square-product bits: issues one LUT index per
// cycle to the external xpb bank and accumulates the returned multiples.
module xpb_fold_accum
    import xpb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SEG*IDX_W-1:0] in_upper,
    input  logic [DATA_W-1:0]        in_lower,
    output logic                     lut_req,
    output logic [SEG_W-1:0]         lut_seg,
    output logic [IDX_W-1:0]         lut_idx,
    input  logic [DATA_W-1:0]        lut_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output state_t                   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; out_valid/out_data hold until that edge, and in_ready may depend on out_ready.

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEG_W-1:0] r_seg_cnt;
    logic [IDX_W-1:0] r_idx [NUM_SEG];
    logic             r_req_d;
    logic             w_accept;
    logic             w_last_seg;

    assign w_accept   = in_valid & in_ready;
    assign w_last_seg = (r_seg_cnt == SEG_W'(NUM_SEG - 1));
    assign dbg_state  = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        lut_req     = 1'b0;
        lut_seg     = '0;
        lut_idx     = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                lut_req = 1'b1;
                lut_seg = r_seg_cnt;
                lut_idx = r_idx[r_seg_cnt];
                if (w_last_seg) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                // A result leaving on the same edge as a new operand arriving skips IDLE.
                if (out_ready) begin
                    w_state_nxt = in_valid ? ISSUE : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_cnt <= '0;
            r_req_d   <= 1'b0;
            for (int s = 0; s < NUM_SEG; s++) begin
                r_idx[s] <= '0;
            end
        end else begin
            // Tracks the bank's one-cycle latency so lut_data is only summed when it answers a request.
            r_req_d <= lut_req;
            if (w_accept) begin
                r_seg_cnt <= '0;
                for (int s = 0; s < NUM_SEG; s++) begin
                    r_idx[s] <= in_upper[s*IDX_W +: IDX_W];
                end
            end else if (r_state == ISSUE) begin
                r_seg_cnt <= r_seg_cnt + SEG_W'(1);
            end
        end
    end

    xpb_acc_add u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_add      (r_req_d),
        .i_load_val (in_lower),
        .i_add_val  (lut_data),
        .o_acc      (out_data)
    );

endmodule

// File: tb/tb_xpb_fold_accum.sv
// Bench for xpb_fold_accum: registered LUT model, directed corner cases and a
// randomized run scored against a plain-arithmetic fold model.
module tb_xpb_fold_accum;
  import xpb_pkg::*;

  localparam int UP_W = NUM_SEG * IDX_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [UP_W-1:0]   in_upper;
  logic [DATA_W-1:0] in_lower;
  logic              lut_req;
  logic [SEG_W-1:0]  lut_seg;
  logic [IDX_W-1:0]  lut_idx;
  logic [DATA_W-1:0] lut_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  state_t            dbg_state;

  logic [ACC_W-1:0]  exp_q[$];
  int                n_checks = 0;
  int                n_pass   = 0;
  int                n_sent   = 0;
  int                n_hs     = 0;
  bit                lut_ones = 0;
  bit                rand_rdy = 0;

  xpb_fold_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_upper  (in_upper),
    .in_lower  (in_lower),
    .lut_req   (lut_req),
    .lut_seg   (lut_seg),
    .lut_idx   (lut_idx),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // LUT bank model: one-cycle registered answer; garbage when not requested
  always @(posedge clk) begin
    if (lut_req)
      lut_data <= lut_ones ? {DATA_W{1'b1}} : DATA_W'(lut_seg) * 32 + DATA_W'(lut_idx);
    else
      lut_data <= {32{$urandom}};
  end

  // random downstream backpressure
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h..%h exp=%h..%h", tag,
                  got[ACC_W-1 -: 64], got[63:0], exp[ACC_W-1 -: 64], exp[63:0]);
  endtask

  // reference: seed plus the table value of every segment
  function automatic logic [ACC_W-1:0] ref_fold(input logic [UP_W-1:0] up,
                                                input logic [DATA_W-1:0] lo, input bit ones);
    logic [ACC_W-1:0] sum;
    sum = ACC_W'(lo);
    for (int s = 0; s < NUM_SEG; s++) begin
      if (ones) sum = sum + ACC_W'({DATA_W{1'b1}});
      else      sum = sum + ACC_W'(s * 32 + int'(up[s*IDX_W +: IDX_W]));
    end
    return sum;
  endfunction

  function automatic logic [DATA_W-1:0] rand_wide();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [UP_W-1:0] rand_upper();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[UP_W-1:0];
  endfunction

  // scoreboard: every result handshake pops one expected value
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_hs++;
      if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
    end
  end

  // driver: present operand until accepted, then release the bus
  task automatic send_op(input logic [UP_W-1:0] up, input logic [DATA_W-1:0] lo);
    int w;
    w = 0;
    exp_q.push_back(ref_fold(up, lo, lut_ones));
    n_sent++;
    in_valid = 1'b1;
    in_upper = up;
    in_lower = lo;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_upper = rand_upper();
    in_lower = rand_wide();
  endtask

  // cycles counted with the accept cycle as cycle 0
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int wait_cyc;
    logic [ACC_W-1:0] held_exp;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_upper  = '0;
    in_lower  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_lut_req", lut_req, 0);
    check("rst_lut_seg", lut_seg, 0);
    check("rst_lut_idx", lut_idx, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_state", dbg_state, IDLE);

    // 1) zero indices still fold in the per-segment weights
    send_op('0, DATA_W'('h1234));
    wait_out(lat);
    check("t1_latency", lat, 10);
    check("t1_const", out_data, 'h15B4);
    take_result();

    // 2) all indices 31: issue sequence and busy in_ready
    send_op({UP_W{1'b1}}, '0);
    for (int n = 1; n <= 9; n++) begin
      check("t2_req", lut_req, (n <= 8));
      if (n <= 8) begin
        check("t2_seg", lut_seg, n - 1);
        check("t2_idx", lut_idx, 31);
      end
      check("t2_in_ready_busy", in_ready, 0);
      @(posedge clk);
      #1;
    end
    check("t2_out_valid", out_valid, 1);
    check("t2_const", out_data, 1144);
    take_result();

    // 3) saturated LUT and seed: no truncation in the top bits
    lut_ones = 1;
    send_op(rand_upper(), {DATA_W{1'b1}});
    wait_out(lat);
    check("t3_top4", out_data[ACC_W-1 -: 4], 4'h8);
    check("t3_low", out_data[31:0], 32'hFFFF_FFF7);
    take_result();
    lut_ones = 0;

    // 4) stall in DONE, then back-to-back accept
    send_op(rand_upper(), rand_wide());
    wait_out(lat);
    held_exp = exp_q[0];
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_data", out_data, held_exp);
      check("t4_in_ready_stall", in_ready, 0);
      check("t4_hold_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_op(rand_upper(), rand_wide());
    out_ready = 1'b0;
    wait_out(lat);
    check("t4_b2b_latency", lat, 10);
    take_result();

    // 5) reset mid-issue discards the operation
    send_op({UP_W{1'b1}}, {DATA_W{1'b1}});
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t5_seg_before_rst", lut_seg, 3);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    n_sent--;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_lut_req", lut_req, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_op('0, DATA_W'(5));
    wait_out(lat);
    check("t5_latency", lat, 10);
    check("t5_const", out_data, 5 + 896);
    take_result();

    // 6) randomized operands with random backpressure and input gaps
    rand_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [UP_W-1:0]   up;
      logic [DATA_W-1:0] lo;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      case ($urandom_range(0, 7))
        0:       up = '0;
        1:       up = {UP_W{1'b1}};
        default: up = rand_upper();
      endcase
      lo = ($urandom_range(0, 7) == 0) ? {DATA_W{1'b1}} : rand_wide();
      send_op(up, lo);
    end
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 500) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    rand_rdy = 0;
    #2;
    out_ready = 1'b0;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_handshakes", n_hs, n_sent);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
